query_crc5_tx: RTL and testbench

QUERY_CRC5_TX -- requirements
Module: query_crc5_tx

---
 rtl/query_crc5_tx_if.sv | 32 +++
 rtl/query_crc5_tx.sv | 189 ++++++++++++++++++
 tb/tb_query_crc5_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/query_crc5_tx_if.sv
// Query frame transmitter bus.
// Groups the frame request (start/abort), the bit-rate strobe, the Query
// field inputs and the serial/status outputs of query_crc5_tx.
//   master : frame requester / bit consumer (drives start, abort, bit_en, fields)
//   slave  : the transmitter itself (drives bitout, bitvalid, busy, done, crc_out)
interface query_crc5_tx_if;
    logic       start;
    logic       abort;
    logic       bit_en;
    logic       dr;
    logic [1:0] m;
    logic       trext;
    logic [1:0] sel;
    logic [1:0] session;
    logic       target;
    logic [3:0] q;
    logic       bitout;
    logic       bitvalid;
    logic       busy;
    logic       done;
    logic [4:0] crc_out;

    modport master (
        output start, abort, bit_en, dr, m, trext, sel, session, target, q,
        input  bitout, bitvalid, busy, done, crc_out
    );

    modport slave (
        input  start, abort, bit_en, dr, m, trext, sel, session, target, q,
        output bitout, bitvalid, busy, done, crc_out
    );
endinterface

// File: rtl/query_crc5_tx.sv
// Serial transmitter for a Query command frame protected by CRC5.
// A frame is 17 payload bits {CMD_CODE, dr, m, trext, sel, session, target, q}
// followed by the 5-bit CRC (x^5+x^3+1, preset CRC_PRESET), all MSB first,
// one bit per sampled bit_en strobe: 22 bits in total.
// Ports:
//   clk           : single clock, all state changes on its rising edge
//   masterreset_n : asynchronous active-low reset
//   bus (slave)   : start/abort/bit_en/fields in; bitout, bitvalid, busy,
//                   done, crc_out out (all registered)
module query_crc5_tx #(
    parameter logic [3:0] CMD_CODE   = 4'b1000,
    parameter logic [4:0] CRC_PRESET = 5'b01001
) (
    input  logic           clk,
    input  logic           masterreset_n,
    query_crc5_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PAYLOAD = 2'b01,
        CRC     = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [16:0] sr_r, sr_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [4:0]  crc_r, crc_s;
    logic [4:0]  crc_sh_r, crc_sh_s;
    logic [4:0]  crc_out_r, crc_out_s;
    logic [4:0]  crc_step_s;
    logic        busy_r, busy_s;
    logic        bitout_r, bitout_s;
    logic        bitvalid_r, bitvalid_s;
    logic        done_r, done_s;

    // One serial CRC5 step (x^5+x^3+1) for input bit b.
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
        logic f;
        f = b ^ crc[4];
        crc5_step = {crc[3], crc[2] ^ f, crc[1], crc[0], f};
    endfunction

    assign crc_step_s = crc5_step(crc_r, sr_r[16]);

    // State register.
    always_ff @(posedge clk or negedge masterreset_n) begin
        if (!masterreset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort wins over bit_en and also vetoes a start in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_s = PAYLOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            PAYLOAD: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (bus.bit_en && (cnt_r == 5'd16)) begin
                    state_s = CRC;
                end else begin
                    state_s = PAYLOAD;
                end
            end
            CRC: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (bus.bit_en && (cnt_r == 5'd4)) begin
                    state_s = IDLE;
                end else begin
                    state_s = CRC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath and output next values. A bit_en on the accept edge is not
    // looked at because IDLE only reacts to start.
    always_comb begin
        sr_s       = sr_r;
        cnt_s      = cnt_r;
        crc_s      = crc_r;
        crc_sh_s   = crc_sh_r;
        crc_out_s  = crc_out_r;
        busy_s     = busy_r;
        bitout_s   = bitout_r;
        bitvalid_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    sr_s   = {CMD_CODE, bus.dr, bus.m, bus.trext, bus.sel,
                              bus.session, bus.target, bus.q};
                    crc_s  = CRC_PRESET;
                    cnt_s  = 5'd0;
                    busy_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            PAYLOAD: begin
                if (bus.abort) begin
                    busy_s = 1'b0;
                end else if (bus.bit_en) begin
                    bitout_s   = sr_r[16];
                    bitvalid_s = 1'b1;
                    sr_s       = {sr_r[15:0], 1'b0};
                    crc_s      = crc_step_s;
                    if (cnt_r == 5'd16) begin
                        // Snapshot includes the 17th bit's CRC update.
                        cnt_s    = 5'd0;
                        crc_sh_s = crc_step_s;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    busy_s = 1'b1;
                end
            end
            CRC: begin
                if (bus.abort) begin
                    busy_s = 1'b0;
                end else if (bus.bit_en) begin
                    bitout_s   = crc_sh_r[4];
                    bitvalid_s = 1'b1;
                    crc_sh_s   = {crc_sh_r[3:0], 1'b0};
                    if (cnt_r == 5'd4) begin
                        cnt_s     = 5'd0;
                        done_s    = 1'b1;
                        busy_s    = 1'b0;
                        crc_out_s = crc_r;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge masterreset_n) begin
        if (!masterreset_n) begin
            sr_r       <= 17'd0;
            cnt_r      <= 5'd0;
            crc_r      <= 5'd0;
            crc_sh_r   <= 5'd0;
            crc_out_r  <= 5'd0;
            busy_r     <= 1'b0;
            bitout_r   <= 1'b0;
            bitvalid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            sr_r       <= sr_s;
            cnt_r      <= cnt_s;
            crc_r      <= crc_s;
            crc_sh_r   <= crc_sh_s;
            crc_out_r  <= crc_out_s;
            busy_r     <= busy_s;
            bitout_r   <= bitout_s;
            bitvalid_r <= bitvalid_s;
            done_r     <= done_s;
        end
    end

    assign bus.bitout   = bitout_r;
    assign bus.bitvalid = bitvalid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.crc_out  = crc_out_r;

endmodule

// File: tb/tb_query_crc5_tx.sv
// Directed bench for query_crc5_tx: table of hand-computed frames plus
// sequences for abort, restart-while-busy, async reset and random frames.
module tb_query_crc5_tx;

    logic clk;
    logic rst_n;
    query_crc5_tx_if qif();

    query_crc5_tx dut (
        .clk           (clk),
        .masterreset_n (rst_n),
        .bus           (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] fields;   // {dr, m, trext, sel, session, target, q}
        int          gap;      // idle cycles between strobes
        logic [21:0] frame;    // expected 22 emitted bits, first bit at [21]
    } vec_t;

    vec_t tbl [6];

    int          total = 0;
    int          bad   = 0;
    logic [63:0] cap;
    int          cap_n;
    int          cap_done;
    int          done_at;
    bit          done_alone;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_fields(input logic [12:0] f);
        {qif.dr, qif.m, qif.trext, qif.sel, qif.session, qif.target, qif.q} = f;
    endtask

    task automatic clear_cap();
        cap        = 64'd0;
        cap_n      = 0;
        cap_done   = 0;
        done_at    = -1;
        done_alone = 1'b0;
    endtask

    // Drive one cycle of inputs, then sample outputs 1 ns after the edge.
    task automatic clk_step(input logic en, input logic st, input logic ab);
        qif.bit_en = en;
        qif.start  = st;
        qif.abort  = ab;
        @(posedge clk);
        #1;
        if (qif.bitvalid) begin
            cap = {cap[62:0], qif.bitout};
            cap_n++;
        end
        if (qif.done) begin
            cap_done++;
            done_at = cap_n;
            if (!qif.bitvalid) done_alone = 1'b1;
        end
    endtask

    // Reference tag-side CRC5 check over a whole received frame.
    function automatic logic [4:0] ref_residue(input logic [21:0] bits);
        logic [4:0] c;
        logic       f;
        c = 5'b01001;
        for (int i = 21; i >= 0; i--) begin
            f = bits[i] ^ c[4];
            c = {c[3], c[2] ^ f, c[1], c[0], f};
        end
        return c;
    endfunction

    // Send one frame and check its framing; bits are left in cap[21:0].
    task automatic run_frame(input logic [12:0] f, input int gap);
        int  cyc;
        int  phase;
        bit  busy_drop;
        clear_cap();
        set_fields(f);
        clk_step(1'b1, 1'b1, 1'b0);          // bit_en on accept edge must be ignored
        chk("accept_busy", qif.busy, 1);
        chk("accept_no_bit", qif.bitvalid, 0);
        set_fields(13'($urandom));           // fields are don't-care now
        cyc = 0;
        phase = 0;
        busy_drop = 1'b0;
        while (cap_n < 22 && cyc < 400) begin
            clk_step((phase == gap) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            phase = (phase == gap) ? 0 : phase + 1;
            cyc++;
            if (cap_n < 22 && !qif.busy) busy_drop = 1'b1;
        end
        chk("bit_count", cap_n, 22);
        chk("busy_held", busy_drop, 0);
        chk("done_count", cap_done, 1);
        chk("done_on_last", done_at, 22);
        chk("done_with_bit", done_alone, 0);
        clk_step(1'b1, 1'b0, 1'b0);
        chk("post_valid", qif.bitvalid, 0);
        chk("post_done", qif.done, 0);
        chk("post_busy", qif.busy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{13'h0000, 0, 22'b1000_0_00_0_00_00_0_0000_10000};
        tbl[1] = '{13'h1FFF, 0, 22'b1000_1_11_1_11_11_1_1111_00111};
        tbl[2] = '{13'h1000, 0, 22'b1000_1_00_0_00_00_0_0000_01000};
        tbl[3] = '{13'h0001, 0, 22'b1000_0_00_0_00_00_0_0001_11001};
        tbl[4] = '{13'h0010, 0, 22'b1000_0_00_0_00_00_1_0000_01101};
        tbl[5] = '{13'h0000, 2, 22'b1000_0_00_0_00_00_0_0000_10000};

        rst_n = 1'b0;
        qif.start = 1'b0; qif.abort = 1'b0; qif.bit_en = 1'b0;
        set_fields(13'h0000);
        clear_cap();
        #1;
        chk("rst_busy", qif.busy, 0);
        chk("rst_bitvalid", qif.bitvalid, 0);
        chk("rst_done", qif.done, 0);
        chk("rst_bitout", qif.bitout, 0);
        chk("rst_crc_out", qif.crc_out, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].fields, tbl[i].gap);
            chk("frame_bits", cap[21:0], tbl[i].frame);
            chk("frame_crc_out", qif.crc_out, tbl[i].frame[4:0]);
        end

        // Abort with bit_en after the 10th bit; previous crc_out is 00111.
        run_frame(13'h1FFF, 0);
        chk("pre_abort_crc", qif.crc_out, 5'b00111);
        clear_cap();
        set_fields(13'h0000);
        clk_step(1'b1, 1'b1, 1'b0);
        repeat (10) clk_step(1'b1, 1'b0, 1'b0);
        chk("abort_bits_before", cap_n, 10);
        chk("abort_prefix", cap[9:0], 10'b1000000000);
        clk_step(1'b1, 1'b0, 1'b1);
        chk("abort_valid", qif.bitvalid, 0);
        chk("abort_done", qif.done, 0);
        chk("abort_busy", qif.busy, 0);
        chk("abort_crc_out", qif.crc_out, 5'b00111);
        repeat (5) clk_step(1'b1, 1'b0, 1'b0);
        chk("abort_no_more_bits", cap_n, 10);
        chk("abort_no_done", cap_done, 0);
        // abort together with start in IDLE rejects the start
        clk_step(1'b1, 1'b1, 1'b1);
        chk("idle_abort_start_busy", qif.busy, 0);
        repeat (3) clk_step(1'b1, 1'b0, 1'b0);
        chk("idle_abort_start_bits", cap_n, 10);
        chk("idle_abort_crc_out", qif.crc_out, 5'b00111);

        // Second start mid-frame with different fields is ignored.
        clear_cap();
        set_fields(13'h0000);
        clk_step(1'b1, 1'b1, 1'b0);
        set_fields(13'h1FFF);
        repeat (5) clk_step(1'b1, 1'b0, 1'b0);
        clk_step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && cap_n < 22; i++) clk_step(1'b1, 1'b0, 1'b0);
        chk("restart_bits", cap[21:0], 22'b1000_0_00_0_00_00_0_0000_10000);
        chk("restart_done", cap_done, 1);
        chk("restart_crc_out", qif.crc_out, 5'b10000);

        // Reset asserted in the CRC state, away from the clock edge.
        clear_cap();
        set_fields(13'h0000);
        clk_step(1'b1, 1'b1, 1'b0);
        repeat (18) clk_step(1'b1, 1'b0, 1'b0);
        chk("pre_rst_bitout", qif.bitout, 1);
        chk("pre_rst_busy", qif.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", qif.busy, 0);
        chk("arst_bitvalid", qif.bitvalid, 0);
        chk("arst_done", qif.done, 0);
        chk("arst_bitout", qif.bitout, 0);
        chk("arst_crc_out", qif.crc_out, 0);
        #3 rst_n = 1'b1;
        chk("arst_no_done", cap_done, 0);
        run_frame(13'h0010, 0);
        chk("post_rst_bits", cap[21:0], 22'b1000_0_00_0_00_00_1_0000_01101);
        chk("post_rst_crc_out", qif.crc_out, 5'b01101);

        // Random frames through the reference CRC5 checker.
        for (int n = 0; n < 1000; n++) begin
            run_frame(13'($urandom), 0);
            chk("residue", ref_residue(cap[21:0]), 5'b00000);
            chk("rand_crc_out", qif.crc_out, cap[4:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
